// File: rtl/game_ctrl_pacman.sv
// Game-level sequencer for Pac-Man: owns game phase, lives, BCD score and dot budget,
// and drives soft_reset/freeze into the movers. All outputs are registered.
module game_ctrl_pacman #(
    parameter int LIVES_INIT   = 3,
    parameter int DEATH_FRAMES = 60,
    parameter int TOTAL_DOTS   = 96
) (
    input  logic        clk_25,
    input  logic        rst,
    input  logic        frame_tick,
    input  logic        hit,
    input  logic        dot_eaten,
    input  logic        btn_start,
    output logic        soft_reset,
    output logic        freeze,
    output logic [2:0]  lives,
    output logic [15:0] score_bcd,
    output logic [2:0]  state,
    output logic        game_over,
    output logic        win
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_PLAY  = 3'd1;
    localparam logic [2:0] ST_DYING = 3'd2;
    localparam logic [2:0] ST_OVER  = 3'd3;
    localparam logic [2:0] ST_WIN   = 3'd4;

    localparam logic [2:0] LIVES_LOAD = 3'(LIVES_INIT);
    localparam logic [9:0] DOTS_LOAD  = 10'(TOTAL_DOTS);
    localparam logic [7:0] FRAME_LAST = 8'(DEATH_FRAMES - 1);

    // Saturating 4-digit BCD increment; 9999 holds.
    function automatic logic [15:0] bcd_inc(input logic [15:0] value);
        logic [15:0] result;
        logic        carry;
        result = value;
        carry  = 1'b1;
        if (value == 16'h9999) begin
            result = value;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (carry) begin
                    if (value[i*4 +: 4] == 4'd9) begin
                        result[i*4 +: 4] = 4'd0;
                        carry            = 1'b1;
                    end else begin
                        result[i*4 +: 4] = value[i*4 +: 4] + 4'd1;
                        carry            = 1'b0;
                    end
                end else begin
                    result[i*4 +: 4] = value[i*4 +: 4];
                end
            end
        end
        return result;
    endfunction

    logic        btn_start_q_r;
    logic [9:0]  dots_left_r;
    logic [7:0]  frame_cnt_r;
    logic        start_rise_s;
    logic        start_load_s;
    logic        win_now_s;
    logic [2:0]  nxt_state_s;
    logic [2:0]  nxt_lives_s;
    logic [15:0] nxt_score_s;
    logic [9:0]  nxt_dots_s;
    logic [7:0]  nxt_frame_s;

    assign start_rise_s = btn_start & ~btn_start_q_r;

    // Next-state and datapath updates for each game phase.
    always_comb begin
        nxt_state_s  = state;
        nxt_lives_s  = lives;
        nxt_score_s  = score_bcd;
        nxt_dots_s   = dots_left_r;
        nxt_frame_s  = frame_cnt_r;
        start_load_s = 1'b0;
        win_now_s    = 1'b0;
        case (state)
            ST_IDLE, ST_OVER, ST_WIN: begin
                if (start_rise_s) begin
                    nxt_state_s  = ST_PLAY;
                    nxt_lives_s  = LIVES_LOAD;
                    nxt_score_s  = 16'h0000;
                    nxt_dots_s   = DOTS_LOAD;
                    start_load_s = 1'b1;
                end else begin
                    nxt_state_s = state;
                end
            end
            ST_PLAY: begin
                // The dot is credited before a simultaneous hit is considered.
                if (dot_eaten) begin
                    nxt_score_s = bcd_inc(score_bcd);
                    nxt_dots_s  = dots_left_r - 10'd1;
                    win_now_s   = (dots_left_r == 10'd1);
                end else begin
                    win_now_s = 1'b0;
                end
                if (win_now_s) begin
                    nxt_state_s = ST_WIN;
                end else if (hit) begin
                    nxt_state_s = ST_DYING;
                    nxt_lives_s = (lives != 3'd0) ? (lives - 3'd1) : 3'd0;
                    nxt_frame_s = 8'd0;
                end else begin
                    nxt_state_s = ST_PLAY;
                end
            end
            ST_DYING: begin
                if (frame_tick) begin
                    if (frame_cnt_r == FRAME_LAST) begin
                        nxt_state_s = (lives == 3'd0) ? ST_OVER : ST_PLAY;
                    end else begin
                        nxt_frame_s = frame_cnt_r + 8'd1;
                    end
                end else begin
                    nxt_frame_s = frame_cnt_r;
                end
            end
            default: begin
                nxt_state_s = ST_IDLE;
            end
        endcase
    end

    // State, datapath and output registers; outputs derive from the next state.
    always_ff @(posedge clk_25 or negedge rst) begin
        if (!rst) begin
            state         <= ST_IDLE;
            lives         <= 3'd0;
            score_bcd     <= 16'h0000;
            dots_left_r   <= 10'd0;
            frame_cnt_r   <= 8'd0;
            btn_start_q_r <= 1'b0;
            freeze        <= 1'b1;
            soft_reset    <= 1'b0;
            game_over     <= 1'b0;
            win           <= 1'b0;
        end else begin
            state         <= nxt_state_s;
            lives         <= nxt_lives_s;
            score_bcd     <= nxt_score_s;
            dots_left_r   <= nxt_dots_s;
            frame_cnt_r   <= nxt_frame_s;
            btn_start_q_r <= btn_start;
            freeze        <= (nxt_state_s != ST_PLAY);
            soft_reset    <= start_load_s | (nxt_state_s == ST_DYING);
            game_over     <= (nxt_state_s == ST_OVER);
            win           <= (nxt_state_s == ST_WIN);
        end
    end

endmodule

// File: tb/tb_game_ctrl_pacman.sv
// Directed bench for game_ctrl_pacman: table-driven startup/scoring vectors plus
// hand sequences for death cycles, win tie-break, restart and mid-DYING reset.
module tb_game_ctrl_pacman;

    logic        clk_25 = 1'b0;
    logic        rst = 1'b0;
    logic        frame_tick = 1'b0;
    logic        hit = 1'b0, dot_eaten = 1'b0, btn_start = 1'b0;
    logic        soft_reset, freeze, game_over, win;
    logic [2:0]  lives, state;
    logic [15:0] score_bcd;

    logic        w_hit = 1'b0, w_dot = 1'b0, w_start = 1'b0;
    logic        w_soft_reset, w_freeze, w_game_over, w_win;
    logic [2:0]  w_lives, w_state;
    logic [15:0] w_score;

    int n_tests = 0;
    int n_fail  = 0;

    game_ctrl_pacman dut (
        .clk_25(clk_25), .rst(rst), .frame_tick(frame_tick), .hit(hit),
        .dot_eaten(dot_eaten), .btn_start(btn_start), .soft_reset(soft_reset),
        .freeze(freeze), .lives(lives), .score_bcd(score_bcd), .state(state),
        .game_over(game_over), .win(win)
    );

    game_ctrl_pacman #(.LIVES_INIT(3), .DEATH_FRAMES(60), .TOTAL_DOTS(4)) dut_w (
        .clk_25(clk_25), .rst(rst), .frame_tick(frame_tick), .hit(w_hit),
        .dot_eaten(w_dot), .btn_start(w_start), .soft_reset(w_soft_reset),
        .freeze(w_freeze), .lives(w_lives), .score_bcd(w_score), .state(w_state),
        .game_over(w_game_over), .win(w_win)
    );

    always #20 clk_25 = ~clk_25;

    typedef struct {
        logic        st, ht, de, ft;
        logic [2:0]  e_state, e_lives;
        logic [15:0] e_score;
        logic        e_soft, e_freeze;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_25);
        #1;
    endtask

    task automatic frames(input int n);
        for (int k = 0; k < n; k++) begin
            frame_tick = 1'b1;
            step();
            frame_tick = 1'b0;
            step();
        end
    endtask

    task automatic chk_main(input string name, input logic [2:0] e_state, input logic [2:0] e_lives,
                            input logic [15:0] e_score, input logic e_soft, input logic e_freeze);
        chk({name, "_state"}, {13'd0, state}, {13'd0, e_state});
        chk({name, "_lives"}, {13'd0, lives}, {13'd0, e_lives});
        chk({name, "_score"}, score_bcd, e_score);
        chk({name, "_soft"}, {15'd0, soft_reset}, {15'd0, e_soft});
        chk({name, "_freeze"}, {15'd0, freeze}, {15'd0, e_freeze});
    endtask

    initial begin
        //              st    ht    de    ft    state lives score     soft  freeze
        vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 3'd3, 16'h0000, 1'b1, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 3'd3, 16'h0000, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 3'd1, 3'd3, 16'h0001, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 1'b0, 1'b1, 1'b0, 3'd1, 3'd3, 16'h0002, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 3'd3, 16'h0002, 1'b0, 1'b0};
        vecs[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 3'd3, 16'h0002, 1'b0, 1'b0};

        #50;
        chk_main("reset", 3'd0, 3'd0, 16'h0000, 1'b0, 1'b1);
        chk("reset_game_over", {15'd0, game_over}, 16'd0);
        chk("reset_win", {15'd0, win}, 16'd0);
        rst = 1'b1;
        step();
        step();

        // Win tie-break on the 4-dot instance
        w_start = 1'b1;
        step();
        w_start = 1'b0;
        chk("w_start_state", {13'd0, w_state}, 16'd1);
        chk("w_start_soft", {15'd0, w_soft_reset}, 16'd1);
        w_dot = 1'b1;
        step();
        step();
        step();
        w_hit = 1'b1;
        step();
        w_dot = 1'b0;
        w_hit = 1'b0;
        chk("w_win_state", {13'd0, w_state}, 16'd4);
        chk("w_win_flag", {15'd0, w_win}, 16'd1);
        chk("w_win_lives", {13'd0, w_lives}, 16'd3);
        chk("w_win_score", w_score, 16'h0004);
        chk("w_win_freeze", {15'd0, w_freeze}, 16'd1);
        w_start = 1'b1;
        step();
        w_start = 1'b0;
        chk("w_restart_state", {13'd0, w_state}, 16'd1);
        chk("w_restart_score", w_score, 16'h0000);
        w_dot = 1'b1;
        w_hit = 1'b1;
        step();
        w_dot = 1'b0;
        w_hit = 1'b0;
        chk("w_hitdot_state", {13'd0, w_state}, 16'd2);
        chk("w_hitdot_score", w_score, 16'h0001);
        chk("w_hitdot_lives", {13'd0, w_lives}, 16'd2);

        // Table-driven startup and scoring on the main instance
        for (int i = 0; i < 6; i++) begin
            btn_start  = vecs[i].st;
            hit        = vecs[i].ht;
            dot_eaten  = vecs[i].de;
            frame_tick = vecs[i].ft;
            step();
            chk_main($sformatf("vec%0d", i), vecs[i].e_state, vecs[i].e_lives,
                     vecs[i].e_score, vecs[i].e_soft, vecs[i].e_freeze);
        end
        btn_start  = 1'b0;
        frame_tick = 1'b0;

        dot_eaten = 1'b1;
        for (int i = 0; i < 17; i++) step();
        dot_eaten = 1'b0;
        chk("score_19", score_bcd, 16'h0019);

        // Saturation at 9999
        force dut.score_bcd = 16'h9998;
        #1;
        release dut.score_bcd;
        dot_eaten = 1'b1;
        step();
        chk("score_9999", score_bcd, 16'h9999);
        step();
        dot_eaten = 1'b0;
        chk("score_sat", score_bcd, 16'h9999);

        // Three deaths; the first holds hit and tries dots during DYING
        for (int d = 0; d < 3; d++) begin
            hit = 1'b1;
            step();
            chk_main($sformatf("death%0d_entry", d), 3'd2, 3'(2 - d), 16'h9999, 1'b1, 1'b1);
            if (d == 0) begin
                dot_eaten = 1'b1;
                step();
                step();
                step();
                dot_eaten = 1'b0;
                chk("held_hit_lives", {13'd0, lives}, 16'd2);
                chk("dying_dot_ignored", score_bcd, 16'h9999);
            end
            hit = 1'b0;
            frames(59);
            chk("dying_59_state", {13'd0, state}, 16'd2);
            chk("dying_59_soft", {15'd0, soft_reset}, 16'd1);
            frame_tick = 1'b1;
            step();
            frame_tick = 1'b0;
            if (d < 2) begin
                chk_main($sformatf("death%0d_exit", d), 3'd1, 3'(2 - d), 16'h9999, 1'b0, 1'b0);
            end else begin
                chk_main("over", 3'd3, 3'd0, 16'h9999, 1'b0, 1'b1);
                chk("over_flag", {15'd0, game_over}, 16'd1);
            end
        end

        // Restart from OVER with a held button
        btn_start = 1'b1;
        step();
        chk_main("restart", 3'd1, 3'd3, 16'h0000, 1'b1, 1'b0);
        chk("restart_game_over", {15'd0, game_over}, 16'd0);
        step();
        chk("restart_soft_fall", {15'd0, soft_reset}, 16'd0);
        step();
        step();
        chk_main("restart_held", 3'd1, 3'd3, 16'h0000, 1'b0, 1'b0);
        btn_start = 1'b0;

        // Reset at frame 30 of DYING
        hit = 1'b1;
        step();
        hit = 1'b0;
        frames(30);
        chk("mid_dying_state", {13'd0, state}, 16'd2);
        #5;
        rst = 1'b0;
        #1;
        chk_main("mid_reset", 3'd0, 3'd0, 16'h0000, 1'b0, 1'b1);
        chk("mid_reset_game_over", {15'd0, game_over}, 16'd0);
        chk("mid_reset_win", {15'd0, win}, 16'd0);
        #20;
        rst = 1'b1;
        step();
        chk("post_reset_idle", {13'd0, state}, 16'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/game_ctrl_pacman.md
# game_ctrl_pacman

Game-level sequencer for the Pac-Man VGA design. It consumes the collision outputs and dot-eaten events, and owns the lives count, BCD score and game phase. It drives `soft_reset` and `freeze` into the player, ghost and dot blocks, which replaces the ad-hoc 10-cycle soft-reset counter in the top level. It sits directly downstream of the three collision checkers and the dot logic, and upstream of the movers and the score/HUD renderer.

## Interface
- `LIVES_INIT`, default 3: lives at game start (1-7).
- `DEATH_FRAMES`, default 60: number of `frame_tick`s spent in DYING.
- `TOTAL_DOTS`, default 96: dots per level (1-1023).
- `clk_25`, input, 1: 25 MHz pixel clock; all logic sits on its rising edge.
- `rst`, input, 1: reset, asynchronous, active-low.
- `frame_tick`, input, 1: one-cycle pulse per frame.
- `hit`, input, 1: OR of the three collision outputs; level-sensitive.
- `dot_eaten`, input, 1: one-cycle pulse per dot consumed.
- `btn_start`, input, 1: start button, already debounced; the block edge-detects it internally.
- `soft_reset`, output, 1: repositions the player, ghosts and dots.
- `freeze`, output, 1: halts all movers.
- `lives`, output, 3: remaining lives.
- `score_bcd`, output, 16: 4-digit BCD score.
- `state`, output, 3: IDLE=0, PLAY=1, DYING=2, OVER=3, WIN=4.
- `game_over`, output, 1: high in OVER.
- `win`, output, 1: high in WIN.

## Operation
- **Start edge.** `start_rise` is `btn_start` & ~`btn_start_q`, with `btn_start_q` registered.
- **IDLE**
  - `freeze`=1.
  - On `start_rise`: go to PLAY, load `lives`=`LIVES_INIT`, `score_bcd`=0, `dots_left`=`TOTAL_DOTS`.
  - Pulse `soft_reset` for 1 cycle.
- **PLAY**
  - `freeze`=0.
  - `dot_eaten`: `score_bcd` increments by 1 with BCD carry per nibble and saturates at 9999; `dots_left` decrements.
  - `dot_eaten` while `dots_left`==1: go to WIN.
  - `hit`, with no win this cycle: `lives` decrements by 1, go to DYING, clear `frame_cnt`.
- **DYING**
  - `freeze`=1, `soft_reset`=1 continuously.
  - Each `frame_tick` increments `frame_cnt`.
  - When `frame_cnt` reaches `DEATH_FRAMES`-1 on a `frame_tick`: go to OVER if `lives`==0, otherwise go to PLAY.
  - Score and dots are kept across a death.
- **OVER / WIN**
  - `freeze`=1.
  - On `start_rise`: behave exactly as the IDLE start (reload and go to PLAY with a 1-cycle `soft_reset`).
- **Ignored inputs.** `hit` is ignored outside PLAY. `dot_eaten` is ignored outside PLAY.
- **Simultaneous events in PLAY**
  - `hit` and `dot_eaten` together: the dot is credited first.
  - If that dot was the last one, WIN wins and no life is lost.
  - Otherwise go to DYING with the dot still credited.
- **Widths**
  - `dots_left` is 10 bits; it cannot underflow because the block exits PLAY at 1.
  - `frame_cnt` is 8 bits; `DEATH_FRAMES` ≤ 255.
  - `lives` never wraps below 0.
- **Undefined states.** States 5-7 return to IDLE on the next clock.

## Timing
- **Reset values:**
  - `state`=IDLE, `freeze`=1, `soft_reset`=0.
  - `lives`=0, `score_bcd`=0, `game_over`=0, `win`=0.
  - Internal: `dots_left`=0, `frame_cnt`=0, `btn_start_q`=0.
- **Registered outputs.** All outputs are registered. The response appears on the cycle after the triggering input edge.
- **DYING duration.** `soft_reset` rises 1 cycle after `hit` and falls on the cycle after the final `frame_tick`. DYING therefore lasts `DEATH_FRAMES` frames, give or take one partial frame at entry.
- **Held `hit`.** `hit` held high through DYING causes no second decrement. If `hit` is still high on re-entry to PLAY, it is taken as a new death on that cycle. The movers being under `soft_reset` makes that case unreachable in the system.
- **Reset mid-operation.** Asserting `rst` in any state returns everything to reset values immediately, with no glitch on `soft_reset`.
- **Start during gameplay.** `start_rise` during PLAY or DYING is ignored.

## Test plan
- **Startup:** reset, then pulse `btn_start` -> `state`=1, `lives`=3, `score_bcd`=0x0000, `soft_reset` high for exactly 1 cycle, `freeze`=0.
- **BCD scoring:** 19 `dot_eaten` pulses in PLAY -> `score_bcd`=0x0019; preload score to 9999 and pulse -> score stays 0x9999.
- **Death cycle:** `hit` in PLAY -> `lives`=2, `state`=2, `soft_reset`=1. After 60 `frame_tick`s -> `state`=1, `soft_reset`=0. Repeat three times in total -> `state`=3, `game_over`=1, `lives`=0.
- **Win with tie-break:** `TOTAL_DOTS`=4. Four dots, with the last one coinciding with `hit` -> `state`=4, `win`=1, `lives` unchanged, `score_bcd`=0x0004.
- **Restart from OVER:** `start_rise` -> `lives`=3, `score`=0, PLAY, 1-cycle `soft_reset`. A held button gives a single restart only.
- **Reset mid-DYING:** assert `rst` at frame 30 of DYING -> all outputs at reset values immediately; `freeze`=1.
